// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path (and later the receive path).
// Holds parity modes, transmitter FSM states and the parity-bit rule.
package uart_pkg;

    localparam int DATA_W_MIN = 5;
    localparam int DATA_W_MAX = 16;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_mode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic logic has_parity(input parity_mode_t mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Data is zero-extended by the caller; zero padding does not change the XOR.
    function automatic logic parity_bit(input logic [DATA_W_MAX-1:0] data,
                                        input parity_mode_t          mode,
                                        input logic                  err);
        logic p;
        p = 1'b0;
        case (mode)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~^data;
            default:  p = 1'b0;
        endcase
        return p ^ err;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: down-counter reloaded at each bit start, bit_end marks its last cycle.
// Shared between the transmit and receive paths.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk_sys,
    input  logic             rst_b,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             bit_end
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, LSB-first data, optional parity, one or two stop bits.
// Frame configuration is latched on each accepted word, so mid-frame input changes are ignored.
//
//   state  | meaning
//   IDLE   | line high, waiting for a word
//   START  | start bit (Tx=0)
//   DATA   | data bit idx_q, LSB first
//   PARITY | parity bit, optionally inverted for error injection
//   STOP   | one or two stop bits; last cycle pulses frame_done and can accept the next word
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    output logic              ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              err_inj,
    input  logic [1:0]        parity_mode,
    input  logic              two_stop,
    input  logic [DIV_W-1:0]  baud_div,
    output logic              Tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    generate
        if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
            $error("uart_tx_frame: DATA_W must lie in 5..16");
        end
    endgenerate

    tx_state_t         state_q,  state_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic              stop2_q,  stop2_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic              err_q,    err_d;
    parity_mode_t      mode_q,   mode_d;
    logic              two_q,    two_d;
    logic [DIV_W-1:0]  div_q,    div_d;

    logic             bit_end;
    logic             last_stop;
    logic             xfer;
    logic             tick_load;
    logic [DIV_W-1:0] tick_val;
    logic             par_bit;

    assign last_stop  = (state_q == STOP) && bit_end && (!two_q || stop2_q);
    assign ready      = (state_q == IDLE) || last_stop;
    assign frame_done = last_stop;
    assign busy       = (state_q != IDLE);
    assign xfer       = valid && ready;

    // A new word restarts the timer with its own divider; otherwise each bit end reloads.
    assign tick_load = xfer || bit_end;
    assign tick_val  = xfer ? baud_div : div_q;

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .clk_sys  (clk),
        .rst_b    (reset),
        .load     (tick_load),
        .load_val (tick_val),
        .bit_end  (bit_end)
    );

    assign par_bit = parity_bit(DATA_W_MAX'(data_q), mode_q, err_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stop2_d = stop2_q;
        data_d  = data_q;
        err_d   = err_q;
        mode_d  = mode_q;
        two_d   = two_q;
        div_d   = div_q;

        case (state_q)
            IDLE: begin
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = has_parity(mode_q) ? PARITY : STOP;
                        stop2_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    stop2_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!two_q || stop2_q) begin
                        state_d = IDLE;
                    end else begin
                        stop2_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Accepting a word overrides the above, which is how back-to-back frames skip IDLE.
        if (xfer) begin
            state_d = START;
            idx_d   = '0;
            stop2_d = 1'b0;
            data_d  = data_in;
            err_d   = err_inj;
            mode_d  = parity_mode_t'(parity_mode);
            two_d   = two_stop;
            div_d   = baud_div;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            stop2_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            mode_q  <= PAR_NONE;
            two_q   <= 1'b0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stop2_q <= stop2_d;
            data_q  <= data_d;
            err_q   <= err_d;
            mode_q  <= mode_d;
            two_q   <= two_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        Tx = 1'b1;
        case (state_q)
            START:   Tx = 1'b0;
            DATA:    Tx = data_q[idx_q];
            PARITY:  Tx = par_bit;
            default: Tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: per-cycle comparison of {Tx,busy,ready,frame_done} against a
// bit-list model of the frame, across directed and randomised frames.
module tb_uart_tx_frame;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic        ready;
    logic [7:0]  data_in;
    logic        err_inj;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic [15:0] baud_div;
    logic        Tx;
    logic        busy;
    logic        frame_done;

    int vectors = 0;
    int errors  = 0;

    logic [3:0] exp_v[$];
    logic [3:0] obs_v[$];

    always #5 clk = ~clk;

    uart_tx_frame #(
        .DATA_W (8),
        .DIV_W  (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid       (valid),
        .ready       (ready),
        .data_in     (data_in),
        .err_inj     (err_inj),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .baud_div    (baud_div),
        .Tx          (Tx),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    // Expected per-cycle {Tx, busy, ready, frame_done} for one frame, appended to exp_v.
    function automatic void model_frame(input logic [7:0] d, input int div, input logic [1:0] mode,
                                        input bit two, input bit err);
        bit bits[$];
        bit p;
        bit last;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (mode == 2'b01 || mode == 2'b10) begin
            p = (($countones(d) % 2) == 1);
            if (mode == 2'b10) p = !p;
            bits.push_back(p ^ err);
        end
        bits.push_back(1'b1);
        if (two) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c <= div; c++) begin
                last = (b == bits.size() - 1) && (c == div);
                exp_v.push_back({bits[b], 1'b1, last, last});
            end
        end
    endfunction

    function automatic void model_idle();
        exp_v.push_back(4'b1010);
    endfunction

    // Sends one frame, scrambles the config inputs mid-frame, records every cycle into obs_v.
    task automatic play_frame(input logic [7:0] d, input int div, input logic [1:0] mode,
                              input bit two, input bit err, input int chg_div, input int chg_mode);
        int n;
        exp_v.delete();
        obs_v.delete();
        model_frame(d, div, mode, two, err);
        model_idle();
        n = exp_v.size();
        @(negedge clk);
        data_in     = d;
        baud_div    = 16'(div);
        parity_mode = mode;
        two_stop    = two;
        err_inj     = err;
        valid       = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs_v.push_back({Tx, busy, ready, frame_done});
            if (i == 0) valid = 1'b0;
            if (i == n / 2) begin
                data_in     = 8'($urandom);
                two_stop    = 1'($urandom);
                err_inj     = 1'($urandom);
                baud_div    = (chg_div  < 0) ? 16'($urandom_range(0, 5)) : 16'(chg_div);
                parity_mode = (chg_mode < 0) ? 2'($urandom)              : 2'(chg_mode);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        valid = 1'b0;
        data_in = '0;
        err_inj = 1'b0;
        parity_mode = 2'b00;
        two_stop = 1'b0;
        baud_div = '0;
        #3;
        vectors++;
        if ({Tx, busy, ready, frame_done} !== 4'b1010) begin
            errors++;
            $display("FAIL reset: tx/busy/rdy/done got %b required 1010", {Tx, busy, ready, frame_done});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        bit ref_seq[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        play_frame(8'hA5, 0, 2'b00, 1'b0, 1'b0, -1, -1);
        for (int i = 0; i < exp_v.size(); i++) begin
            vectors++;
            if (obs_v[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL basic_a5 cycle %0d: tx/busy/rdy/done got %b required %b", i, obs_v[i], exp_v[i]);
            end
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (obs_v[i][3] !== ref_seq[i]) begin
                errors++;
                $display("FAIL basic_a5_tx cycle %0d: got %b required %b", i, obs_v[i][3], ref_seq[i]);
            end
        end
    endtask

    task automatic test_even_div3();
        int busy_cycles;
        play_frame(8'h07, 3, 2'b01, 1'b0, 1'b0, -1, -1);
        for (int i = 0; i < exp_v.size(); i++) begin
            vectors++;
            if (obs_v[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL even_div3 cycle %0d: tx/busy/rdy/done got %b required %b", i, obs_v[i], exp_v[i]);
            end
        end
        busy_cycles = 0;
        foreach (obs_v[i]) if (obs_v[i][2] === 1'b1) busy_cycles++;
        vectors++;
        if (busy_cycles != 44) begin
            errors++;
            $display("FAIL even_div3_len: got %0d busy cycles required 44", busy_cycles);
        end
        vectors++;
        if (obs_v[36][3] !== 1'b1) begin
            errors++;
            $display("FAIL even_div3_parity: got %b required 1", obs_v[36][3]);
        end
    endtask

    task automatic test_odd_err();
        logic [3:0] first_obs[$];
        for (int e = 0; e < 2; e++) begin
            play_frame(8'h07, 0, 2'b10, 1'b0, e[0], -1, -1);
            for (int i = 0; i < exp_v.size(); i++) begin
                vectors++;
                if (obs_v[i] !== exp_v[i]) begin
                    errors++;
                    $display("FAIL odd_err%0d cycle %0d: tx/busy/rdy/done got %b required %b", e, i, obs_v[i], exp_v[i]);
                end
            end
            vectors++;
            if (obs_v[9][3] !== e[0]) begin
                errors++;
                $display("FAIL odd_err%0d_parity: got %b required %b", e, obs_v[9][3], e[0]);
            end
            if (e == 0) first_obs = obs_v;
        end
        for (int i = 1; i < 9; i++) begin
            vectors++;
            if (obs_v[i] !== first_obs[i]) begin
                errors++;
                $display("FAIL odd_err_data cycle %0d: got %b required %b", i, obs_v[i], first_obs[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int done_idx[$];
        exp_v.delete();
        obs_v.delete();
        model_frame(8'h55, 0, 2'b00, 1'b1, 1'b0);
        model_frame(8'hAA, 0, 2'b00, 1'b1, 1'b0);
        model_idle();
        n = exp_v.size();
        @(negedge clk);
        data_in = 8'h55;
        baud_div = '0;
        parity_mode = 2'b00;
        two_stop = 1'b1;
        err_inj = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs_v.push_back({Tx, busy, ready, frame_done});
            if (i == 0) data_in = 8'hAA;
            if (i == 11) valid = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (obs_v[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL b2b cycle %0d: tx/busy/rdy/done got %b required %b", i, obs_v[i], exp_v[i]);
            end
            if (obs_v[i][0] === 1'b1) done_idx.push_back(i);
        end
        vectors++;
        if (done_idx.size() != 2) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d required 2", done_idx.size());
        end else if (done_idx[1] - done_idx[0] != 11) begin
            errors++;
            $display("FAIL b2b_done_gap: got %0d required 11", done_idx[1] - done_idx[0]);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        data_in = 8'h00;
        baud_div = '0;
        parity_mode = 2'b01;
        two_stop = 1'b0;
        err_inj = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) valid = 1'b0;
        end
        vectors++;
        if ({Tx, busy} !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid_pre: tx/busy got %b required 01", {Tx, busy});
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({Tx, busy, ready, frame_done} !== 4'b1010) begin
            errors++;
            $display("FAIL rst_mid_now: tx/busy/rdy/done got %b required 1010", {Tx, busy, ready, frame_done});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({Tx, busy, ready, frame_done} !== 4'b1010) begin
                errors++;
                $display("FAIL rst_mid_hold %0d: tx/busy/rdy/done got %b required 1010", i, {Tx, busy, ready, frame_done});
            end
        end
        reset = 1'b1;
        play_frame(8'h3C, 0, 2'b00, 1'b0, 1'b0, -1, -1);
        for (int i = 0; i < exp_v.size(); i++) begin
            vectors++;
            if (obs_v[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL rst_mid_3c cycle %0d: tx/busy/rdy/done got %b required %b", i, obs_v[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_midframe_change();
        play_frame(8'h5A, 3, 2'b01, 1'b0, 1'b0, 0, 2);
        for (int i = 0; i < exp_v.size(); i++) begin
            vectors++;
            if (obs_v[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL midchg_old cycle %0d: tx/busy/rdy/done got %b required %b", i, obs_v[i], exp_v[i]);
            end
        end
        play_frame(8'h5A, 0, 2'b10, 1'b0, 1'b0, -1, -1);
        for (int i = 0; i < exp_v.size(); i++) begin
            vectors++;
            if (obs_v[i] !== exp_v[i]) begin
                errors++;
                $display("FAIL midchg_new cycle %0d: tx/busy/rdy/done got %b required %b", i, obs_v[i], exp_v[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        int         div;
        logic [1:0] mode;
        bit         two;
        bit         err;
        for (int f = 0; f < 16; f++) begin
            d    = 8'($urandom);
            div  = $urandom_range(0, 3);
            mode = 2'($urandom);
            two  = 1'($urandom);
            err  = 1'($urandom);
            play_frame(d, div, mode, two, err, -1, -1);
            for (int i = 0; i < exp_v.size(); i++) begin
                vectors++;
                if (obs_v[i] !== exp_v[i]) begin
                    errors++;
                    $display("FAIL random f%0d d=%h div=%0d mode=%0d two=%0d err=%0d cycle %0d: got %b required %b",
                             f, d, div, mode, two, err, i, obs_v[i], exp_v[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_even_div3();
        test_odd_err();
        test_back_to_back();
        test_reset_mid();
        test_midframe_change();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
